// File: rtl/spi_xfer_pkg.sv
// Shared types for the SPI transfer controller: FSM state encoding and SPI mode constants.
// SETUP/HOLD states exist only when SPI_XFER_CS_DELAY_EN is defined.
package spi_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
`ifdef SPI_XFER_CS_DELAY_EN
    ST_SETUP = 3'd1,
    ST_HOLD  = 3'd3,
`endif
    ST_XFER  = 3'd2,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int MODE_CPOL_BIT = 1;
  localparam int MODE_CPHA_BIT = 0;

endpackage

// File: rtl/spi_baud_gen.sv
// SCLK half-period counter: counts 0..div-1 while run is high, tick marks the last count.
module spi_baud_gen #(
  parameter int DIV_W = 12
) (
  input  logic             P_clk,
  input  logic             P_rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == div - DIV_W'(1));

  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer controller: slave select, SCLK generation and sample/shift strobes.
// Define SPI_XFER_CS_DELAY_EN to add one half-period of select setup and hold around SCLK.
import spi_xfer_pkg::*;

module spi_xfer_ctrl #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 12
) (
  input  logic                        P_clk,
  input  logic                        P_rst,
  input  logic                        mstr,
  input  logic                        spiswai,
  input  logic [1:0]                  spi_mode,
  input  logic                        send_data,
  input  logic                        abort,
  input  logic [$clog2(NUM_SS):0]     ss_sel,
  input  logic [$clog2(DATA_W)-1:0]   frame_len,
  input  logic [DIV_W-1:0]            baudratedivisor,
  output logic [NUM_SS-1:0]           ss_n,
  output logic                        tip,
  output logic                        sclk,
  output logic                        sample_en,
  output logic                        shift_en,
  output logic                        receive_data,
  output logic                        ovr
);

  // ss_sel carries one spare bit so out-of-range selects can be presented and rejected
  localparam int SS_W = $clog2(NUM_SS) + 1;
  localparam int FL_W = $clog2(DATA_W);
  localparam int EC_W = $clog2(2 * DATA_W) + 1;

  state_t           state;
  logic             cpol_q;
  logic             cpha_q;
  logic [FL_W-1:0]  fl_q;
  logic [DIV_W-1:0] div_q;
  logic [EC_W-1:0]  ecnt;
  logic [EC_W-1:0]  edge_nxt;
  logic [EC_W-1:0]  total;
  logic             en;
  logic             sel_ok;
  logic             start_go;
  logic             run;
  logic             tick;
  logic             last_edge;
  logic             odd_edge;

  assign en        = mstr & ~spiswai;
  assign sel_ok    = ss_sel < SS_W'(NUM_SS);
  assign start_go  = en && (state == ST_IDLE) && send_data && sel_ok;
  assign edge_nxt  = ecnt + EC_W'(1);
  assign total     = (EC_W'(fl_q) + EC_W'(1)) << 1;
  assign last_edge = (edge_nxt == total);
  assign odd_edge  = edge_nxt[0];
  assign tip       = ~&ss_n;

`ifdef SPI_XFER_CS_DELAY_EN
  assign run = (state == ST_SETUP) || (state == ST_XFER) || (state == ST_HOLD);
`else
  assign run = (state == ST_XFER);
`endif

  spi_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .P_clk (P_clk),
    .P_rst (P_rst),
    .run   (run),
    .div   (div_q),
    .tick  (tick)
  );

  // Frame configuration captured at start; held constant for the whole frame
  always_ff @(posedge P_clk) begin
    if (start_go) begin
      cpha_q <= spi_mode[MODE_CPHA_BIT];
      fl_q   <= frame_len;
      div_q  <= (baudratedivisor == '0) ? DIV_W'(1) : baudratedivisor;
    end
  end

  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      state        <= ST_IDLE;
      ss_n         <= '1;
      sclk         <= 1'b0;
      cpol_q       <= 1'b0;
      ecnt         <= '0;
      sample_en    <= 1'b0;
      shift_en     <= 1'b0;
      receive_data <= 1'b0;
      ovr          <= 1'b0;
    end else begin
      sample_en    <= 1'b0;
      shift_en     <= 1'b0;
      receive_data <= 1'b0;
      ovr          <= send_data && (state != ST_IDLE);
      if (!en || (abort && (state != ST_IDLE))) begin
        state <= ST_IDLE;
        ss_n  <= '1;
        sclk  <= cpol_q;
        ecnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (send_data) begin
              if (sel_ok) begin
                cpol_q <= spi_mode[MODE_CPOL_BIT];
                sclk   <= spi_mode[MODE_CPOL_BIT];
                ss_n   <= ~(NUM_SS'(1) << ss_sel);
                ecnt   <= '0;
`ifdef SPI_XFER_CS_DELAY_EN
                state  <= ST_SETUP;
`else
                state  <= ST_XFER;
`endif
              end else begin
                ovr <= 1'b1;
              end
            end
          end
`ifdef SPI_XFER_CS_DELAY_EN
          ST_SETUP: if (tick) state <= ST_XFER;
          ST_HOLD: begin
            if (tick) begin
              state        <= ST_DONE;
              ss_n         <= '1;
              receive_data <= 1'b1;
            end
          end
`endif
          ST_XFER: begin
            if (tick) begin
              sclk <= ~sclk;
              ecnt <= edge_nxt;
              // CPHA=0 samples on leading (odd) edges, CPHA=1 on trailing (even) edges
              if (cpha_q) begin
                shift_en  <= odd_edge;
                sample_en <= ~odd_edge;
              end else begin
                sample_en <= odd_edge;
                shift_en  <= ~odd_edge && !last_edge;
              end
              if (last_edge) begin
`ifdef SPI_XFER_CS_DELAY_EN
                state        <= ST_HOLD;
`else
                state        <= ST_DONE;
                ss_n         <= '1;
                receive_data <= 1'b1;
`endif
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Randomized scoreboard bench for spi_xfer_ctrl; expected per-cycle activity comes from a frame-level model.
module tb_spi_xfer_ctrl;

  localparam int DATA_W = 8;
  localparam int NUM_SS = 4;
  localparam int DIV_W  = 12;
  localparam int SS_W   = $clog2(NUM_SS) + 1;
  localparam int FL_W   = $clog2(DATA_W);
`ifdef SPI_XFER_CS_DELAY_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic              P_clk = 1'b0;
  logic              P_rst = 1'b0;
  logic              mstr = 1'b0;
  logic              spiswai = 1'b0;
  logic [1:0]        spi_mode = 2'b00;
  logic              send_data = 1'b0;
  logic              abort = 1'b0;
  logic [SS_W-1:0]   ss_sel = '0;
  logic [FL_W-1:0]   frame_len = '0;
  logic [DIV_W-1:0]  baudratedivisor = '0;
  logic [NUM_SS-1:0] ss_n;
  logic              tip, sclk, sample_en, shift_en, receive_data, ovr;

  spi_xfer_ctrl #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .DIV_W(DIV_W)) dut (
    .P_clk(P_clk), .P_rst(P_rst), .mstr(mstr), .spiswai(spiswai), .spi_mode(spi_mode),
    .send_data(send_data), .abort(abort), .ss_sel(ss_sel), .frame_len(frame_len),
    .baudratedivisor(baudratedivisor), .ss_n(ss_n), .tip(tip), .sclk(sclk),
    .sample_en(sample_en), .shift_en(shift_en), .receive_data(receive_data), .ovr(ovr)
  );

  always #5 P_clk = ~P_clk;

  int cyc = 0;
  always @(posedge P_clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;
  int exp_samples = 0;
  int got_samples = 0;
  bit mon_on = 1'b0;
  bit last_sclk = 1'b0;

  // Scoreboard keyed by cycle: {sample, shift, receive, ovr}
  logic [3:0]        exp_ev [int];
  logic [NUM_SS-1:0] exp_ss [int];
  logic              exp_sclk [int];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic add_ev(input int c, input logic [3:0] ev);
    if (exp_ev.exists(c)) exp_ev[c] = exp_ev[c] | ev;
    else exp_ev[c] = ev;
  endtask

  // Frame model: select low from start until DONE, edge k visible k half-periods after setup
  task automatic plan(input int S, input logic [1:0] mode, input int sel, input int fl,
                      input int d, input int A, output int endc);
    int D, E, R, stop, ne, c;
    logic cpol, cpha, odd;
    logic [3:0] ev;
    D = CS ? d : 0;
    E = 2 * (fl + 1);
    R = S + 2 * D + E * d;
    stop = (A < 0) ? R + 1 : A;
    cpol = mode[1];
    cpha = mode[0];
    for (int cc = S; cc < stop; cc++) begin
      if (cc < R) exp_ss[cc] = ~(NUM_SS'(1) << sel);
      ne = (cc < S + D) ? 0 : (cc - S - D) / d;
      if (ne > E) ne = E;
      exp_sclk[cc] = cpol ^ ne[0];
    end
    if (A >= 0) exp_sclk[A] = cpol;
    for (int k = 1; k <= E; k++) begin
      c = S + D + k * d;
      if (c < stop) begin
        odd = k[0];
        if (cpha) ev = {~odd, odd, 2'b00};
        else ev = {odd, ~odd && (k != E), 2'b00};
        if (ev[3]) exp_samples++;
        add_ev(c, ev);
      end
    end
    if (A < 0) add_ev(R, 4'b0010);
    endc = (A < 0) ? R : A;
  endtask

  always @(negedge P_clk) begin : monitor
    logic [3:0] got, want;
    logic [NUM_SS-1:0] wss;
    bit has;
    if (mon_on) begin
      if (exp_sclk.exists(cyc)) begin
        last_sclk = exp_sclk[cyc];
        exp_sclk.delete(cyc);
      end
      wss = exp_ss.exists(cyc) ? exp_ss[cyc] : '1;
      if (exp_ss.exists(cyc)) exp_ss.delete(cyc);
      chk("ss_n", ss_n, wss);
      chk("tip", tip, wss != '1);
      chk("sclk", sclk, last_sclk);
      got = {sample_en, shift_en, receive_data, ovr};
      has = exp_ev.exists(cyc);
      want = has ? exp_ev[cyc] : 4'b0000;
      if (has) exp_ev.delete(cyc);
      if (got != 4'b0000 || has) chk("strobes{smp,shf,rcv,ovr}", got, want);
      if (sample_en) got_samples++;
    end
  end

  // kind: 0 normal, 1 send_data held, 2 abort, 3 spiswai, 4 bad select, 5 mstr off
  task automatic run_frame(input logic [1:0] mode, input int sel, input int fl, input int dv,
                           input int kind, input int prm);
    int S, R, A, h, d, D, endc;
    @(negedge P_clk);
    mstr = 1'b1; spiswai = 1'b0; abort = 1'b0;
    spi_mode = mode; ss_sel = SS_W'(sel); frame_len = FL_W'(fl);
    baudratedivisor = DIV_W'(dv);
    send_data = 1'b1;
    if (kind == 5) mstr = 1'b0;
    S = cyc + 1;
    if (kind >= 4) begin
      if (kind == 4) add_ev(S, 4'b0001);
      @(negedge P_clk);
      send_data = 1'b0; mstr = 1'b1;
      repeat (2) @(negedge P_clk);
      return;
    end
    d = (dv == 0) ? 1 : dv;
    D = CS ? d : 0;
    R = S + 2 * D + 2 * (fl + 1) * d;
    A = -1;
    h = 0;
    if (kind == 2 || kind == 3) A = (prm > 0) ? S + prm : $urandom_range(R - 1, S + 1);
    if (kind == 1) h = (prm > 0) ? prm : $urandom_range(R - S, 1);
    plan(S, mode, sel, fl, d, A, endc);
    for (int c = S + 1; c <= S + h; c++) add_ev(c, 4'b0001);
    for (int n = 0; n < 2000 && cyc < endc + 2; n++) begin
      @(negedge P_clk);
      send_data = (kind == 1) && (cyc < S + h);
      abort = (kind == 2) && (cyc == A - 1);
      spiswai = (kind == 3) && (cyc == A - 1);
      spi_mode = 2'($urandom);
      ss_sel = SS_W'($urandom);
      frame_len = FL_W'($urandom);
      baudratedivisor = DIV_W'($urandom_range(6, 0));
    end
    send_data = 1'b0; abort = 1'b0; spiswai = 1'b0;
  endtask

  initial begin
    int dv, k;
    repeat (3) @(negedge P_clk);
    chk("reset ss_n", ss_n, 4'b1111);
    chk("reset tip", tip, 0);
    chk("reset sclk", sclk, 0);
    chk("reset strobes", {sample_en, shift_en, receive_data, ovr}, 0);
    P_rst = 1'b1;
    mon_on = 1'b1;
    @(negedge P_clk);

    run_frame(2'b00, 1, 7, 2, 0, 0);
    run_frame(2'b11, 2, 3, 1, 0, 0);
    run_frame(2'b01, 0, 5, 3, 1, 0);
    run_frame(2'b10, 3, 3, 2, 1, (CS ? 4 : 0) + 16);
    run_frame(2'b00, 1, 7, 2, 2, (CS ? 2 : 0) + 5 * 2 + 1);
    run_frame(2'b01, 2, 7, 1, 3, (CS ? 1 : 0) + 5 + 1);
    run_frame(2'b00, 5, 3, 1, 4, 0);
    run_frame(2'b11, 0, 2, 0, 0, 0);
    run_frame(2'b10, 2, 1, 3, 0, 0);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(5, 0);
      dv = $urandom_range(4, 0);
      run_frame(2'($urandom), (k == 4) ? $urandom_range(7, NUM_SS) : $urandom_range(NUM_SS - 1, 0),
                $urandom_range(DATA_W - 1, 0), dv, k, 0);
      if ($urandom_range(1, 0) == 1) begin
        @(negedge P_clk);
        abort = 1'b1;
        @(negedge P_clk);
        abort = 1'b0;
      end
    end

    repeat (3) @(negedge P_clk);
    mon_on = 1'b0;
    chk("scoreboard drained", exp_ev.num(), 0);
    chk("sample_en count", got_samples, exp_samples);

    // Reset in the middle of a frame abandons it silently
    spi_mode = 2'b10; ss_sel = SS_W'(2); frame_len = FL_W'(7); baudratedivisor = DIV_W'(3);
    send_data = 1'b1;
    @(negedge P_clk);
    send_data = 1'b0;
    repeat (6) @(negedge P_clk);
    chk("mid-frame ss_n", ss_n, 4'b1011);
    #2 P_rst = 1'b0;
    #1;
    chk("async reset ss_n", ss_n, 4'b1111);
    chk("async reset sclk", sclk, 0);
    chk("async reset rcv", receive_data, 0);
    @(negedge P_clk);
    P_rst = 1'b1;
    k = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge P_clk);
      if (receive_data || ss_n != 4'b1111) k++;
    end
    chk("no activity after reset", k, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
